rom_loader: RTL

ROM_LOADER -- requirements
Module: rom_loader

---
 rtl/rom_loader_pkg.sv | 26 ++
 rtl/rom_loader_if.sv | 39 +++
 rtl/rom_loader_csum.sv | 42 ++++
 rtl/rom_loader.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/rom_loader_pkg.sv
// Shared definitions for the ROM loader slice.
// Holds the loader FSM state enumeration, the default ROM address width,
// the maximum load length and a helper that derives the length limit for
// any address width.
package rom_loader_pkg;

  localparam int DEF_ADDR_W = 15;
  localparam int WORD_W     = 16;

  // Largest accepted load length (in words) for the default address width.
  localparam int unsigned MAX_LEN = 32'd1 << DEF_ADDR_W;

  typedef enum logic [2:0] {
    ST_LEN  = 3'd0,
    ST_DATA = 3'd1,
    ST_CSUM = 3'd2,
    ST_RUN  = 3'd3,
    ST_ERR  = 3'd4
  } state_e;

  // Length limit as a 17-bit value so that 2**16 remains representable.
  function automatic logic [16:0] max_len_f(input int unsigned addr_w);
    return 17'(32'd1 << addr_w);
  endfunction

endpackage

// File: rtl/rom_loader_if.sv
// Loader stream and instruction-ROM write bus.
// Signals:
//   in_valid / in_data / in_ready : 16-bit loader stream with valid/ready handshake
//   rom_we / rom_addr / rom_wdata : instruction ROM write port
// Modports:
//   slave  : the loader (consumes the stream, drives the ROM port)
//   master : the environment (produces the stream, observes the ROM port)
interface rom_loader_if
  import rom_loader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
);

  logic                in_valid;
  logic [WORD_W-1:0]   in_data;
  logic                in_ready;
  logic                rom_we;
  logic [ADDR_W-1:0]   rom_addr;
  logic [WORD_W-1:0]   rom_wdata;

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output rom_we,
    output rom_addr,
    output rom_wdata
  );

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  rom_we,
    input  rom_addr,
    input  rom_wdata
  );

endinterface

// File: rtl/rom_loader_csum.sv
// Running 16-bit checksum used by the ROM loader.
// Ports:
//   clk, reset : clock and synchronous active-high reset (clears the sum)
//   clr_i      : clear the sum to zero (wins over add_i)
//   add_i      : add data_i into the sum, modulo 2**16
//   data_i     : 16-bit word to accumulate
//   sum_o      : current registered sum
module loader_csum
  import rom_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_i,
  input  logic              add_i,
  input  logic [WORD_W-1:0] data_i,
  output logic [WORD_W-1:0] sum_o
);

  logic [WORD_W-1:0] sum_q;
  logic [WORD_W-1:0] sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clr_i) begin
      sum_d = '0;
    end else if (add_i) begin
      // Natural 16-bit wrap gives the modulo-2**16 sum.
      sum_d = sum_q + data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/rom_loader.sv
// Boot ROM loader.
// Accepts a word stream of the form: length N, N data words, checksum.
// Each data word is written to the instruction ROM at consecutive addresses
// starting from 0. The CPU is held in reset until the checksum matches; a
// bad length or bad checksum parks the loader in an error state until
// reload is pulsed.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   bus        : stream in (in_valid/in_data/in_ready) and ROM write out
//                (rom_we/rom_addr/rom_wdata), slave side
//   reload     : single-cycle request to start a new load (RUN/ERR only)
//   cpu_reset  : 1 holds the CPU at pc 0; low only once a load succeeded
//   busy       : load in progress (LEN, DATA, CSUM)
//   error      : last load failed
// All outputs apart from in_ready are registered.
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
)(
  input  logic         clk,
  input  logic         reset,
  rom_loader_if.slave  bus,
  input  logic         reload,
  output logic         cpu_reset,
  output logic         busy,
  output logic         error
);

  localparam logic [16:0] MAX_LEN_C = max_len_f(ADDR_W);

  state_e             state_q, state_d;
  logic [16:0]        count_q, count_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               rom_we_q, rom_we_d;
  logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
  logic [WORD_W-1:0]  rom_wdata_q, rom_wdata_d;
  logic               cpu_reset_q, busy_q, error_q;

  logic               in_ready;
  logic               xfer;
  logic               csum_clr, csum_add;
  logic [WORD_W-1:0]  csum;
  logic [16:0]        len_word;
  logic               last_word;

  // Ready is a pure decode of the current state.
  assign in_ready = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CSUM);
  assign xfer     = bus.in_valid && in_ready;
  assign len_word = {1'b0, bus.in_data};

  // Widened compare so that N = 2**ADDR_W terminates on the last address
  // instead of relying on the address counter wrapping.
  assign last_word = ((17'(addr_q) + 17'd1) == count_q);

  loader_csum u_csum (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (csum_clr),
    .add_i  (csum_add),
    .data_i (bus.in_data),
    .sum_o  (csum)
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    addr_d      = addr_q;
    rom_we_d    = 1'b0;
    rom_addr_d  = rom_addr_q;
    rom_wdata_d = rom_wdata_q;
    csum_clr    = 1'b0;
    csum_add    = 1'b0;

    case (state_q)
      ST_LEN: begin
        if (xfer) begin
          count_d  = len_word;
          addr_d   = '0;
          csum_clr = 1'b1;
          if ((len_word == 17'd0) || (len_word > MAX_LEN_C)) begin
            state_d = ST_ERR;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (xfer) begin
          rom_we_d    = 1'b1;
          rom_addr_d  = addr_q;
          rom_wdata_d = bus.in_data;
          csum_add    = 1'b1;
          addr_d      = addr_q + 1'b1;
          if (last_word) begin
            state_d = ST_CSUM;
          end
        end
      end
      ST_CSUM: begin
        if (xfer) begin
          state_d = (bus.in_data == csum) ? ST_RUN : ST_ERR;
        end
      end
      ST_RUN, ST_ERR: begin
        if (reload) begin
          state_d = ST_LEN;
        end
      end
      default: begin
        state_d = ST_LEN;
      end
    endcase
  end

  // Status outputs are registered from the next state so they line up
  // with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_LEN;
      count_q     <= '0;
      addr_q      <= '0;
      rom_we_q    <= 1'b0;
      rom_addr_q  <= '0;
      rom_wdata_q <= '0;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b1;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      addr_q      <= addr_d;
      rom_we_q    <= rom_we_d;
      rom_addr_q  <= rom_addr_d;
      rom_wdata_q <= rom_wdata_d;
      cpu_reset_q <= (state_d != ST_RUN);
      busy_q      <= (state_d == ST_LEN) || (state_d == ST_DATA) || (state_d == ST_CSUM);
      error_q     <= (state_d == ST_ERR);
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.rom_we    = rom_we_q;
  assign bus.rom_addr  = rom_addr_q;
  assign bus.rom_wdata = rom_wdata_q;
  assign cpu_reset     = cpu_reset_q;
  assign busy          = busy_q;
  assign error         = error_q;

endmodule
